// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: shadow register-usage
// tracking, operand forwarding, load-use stall, branch/jump flush and memory wait-state freeze.
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_memwrite,
  input  logic       id_jump,
  input  logic       ex_branch_taken,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       freeze_all,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam bit         WAIT_EN   = (MEM_WAIT != 0);
  localparam bit         WAIT_ONE  = (MEM_WAIT == 1);
  localparam logic [3:0] WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  entry_t     ex_q, mem_q, wb_q, ex_d;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_acc, load_use, bubble;
  logic       shadow_unused;

  function automatic logic counts(input entry_t e);
    return e.valid & e.regwrite & (e.dst != 5'd0);
  endfunction

  // Loads sitting in MEM have no data yet, so they never feed the EX/MEM path.
  function automatic logic [1:0] fwd_sel(input entry_t m, input entry_t w, input logic [4:0] src);
    if (counts(m) && (m.dst == src) && !m.memread) return 2'b10;
    else if (counts(w) && (w.dst == src))         return 2'b01;
    else                                          return 2'b00;
  endfunction

  assign fwd_a   = fwd_sel(mem_q, wb_q, ex_q.rs);
  assign fwd_b   = fwd_sel(mem_q, wb_q, ex_q.rt);
  assign mem_acc = mem_q.valid & (mem_q.memread | mem_q.memwrite);

  assign load_use = ex_q.valid & ex_q.memread & (ex_q.dst != 5'd0) & id_valid &
                    ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));

  // WB only feeds forwarding; its remaining fields are kept for a complete shadow record.
  assign shadow_unused = ^wb_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_all = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_acc && WAIT_EN) begin
          freeze_all = 1'b1;
          cnt_d      = WAIT_LOAD;
          state_d    = WAIT_ONE ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        freeze_all = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Branch beats load-use, load-use beats jump; a frozen pipeline ignores all of them.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (rst_n && !freeze_all) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_valid && id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  assign bubble = ex_branch_taken | idex_bubble | !id_valid;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.uses_rs  = id_uses_rs;
      ex_d.uses_rt  = id_uses_rt;
      ex_d.dst      = id_dst;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!freeze_all) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl: one instance with MEM_WAIT=0
// (forwarding/stall/flush) and one with MEM_WAIT=3 (freeze sequencing).
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_memwrite, id_jump;
  logic       ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_dst;

  logic       pcs0, ifs0, bub0, iff0, ief0, frz0;
  logic [1:0] fa0, fb0;
  logic       pcs3, ifs3, bub3, iff3, ief3, frz3;
  logic [1:0] fa3, fb3;

  pipeline_hazard_ctrl #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_stall(pcs0), .ifid_stall(ifs0), .idex_bubble(bub0), .ifid_flush(iff0),
    .idex_flush(ief0), .freeze_all(frz0), .fwd_a(fa0), .fwd_b(fb0));

  pipeline_hazard_ctrl #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .pc_stall(pcs3), .ifid_stall(ifs3), .idex_bubble(bub3), .ifid_flush(iff3),
    .idex_flush(ief3), .freeze_all(frz3), .fwd_a(fa3), .fwd_b(fb3));

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       rw, mr, mw, j, br;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  // ctl = {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, freeze_all}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b111000;
  localparam logic [5:0] C_BR    = 6'b000110;
  localparam logic [5:0] C_JMP   = 6'b000100;
  localparam logic [5:0] C_FRZ   = 6'b000001;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tv[$];
  vec_t fz[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] dst,
                              input logic rw, input logic mr, input logic mw, input logic j,
                              input logic br, input logic [5:0] ctl, input logic [1:0] fa,
                              input logic [1:0] fb);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.dst = dst;
    x.rw = rw; x.mr = mr; x.mw = mw; x.j = j; x.br = br;
    x.ctl = ctl; x.fa = fa; x.fb = fb;
    return x;
  endfunction

  function automatic vec_t nop(input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, fa, fb);
  endfunction

  function automatic logic [9:0] obs0();
    return {pcs0, ifs0, bub0, iff0, ief0, frz0, fa0, fb0};
  endfunction

  function automatic logic [9:0] obs3();
    return {pcs3, ifs3, bub3, iff3, ief3, frz3, fa3, fb3};
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
    id_dst = x.dst; id_regwrite = x.rw; id_memread = x.mr; id_memwrite = x.mw;
    id_jump = x.j; ex_branch_taken = x.br;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input bit use3, input string tag, input int idx);
    drive(x);
    @(negedge clk);
    if (use3) begin
      check($sformatf("%s[%0d]", tag, idx), obs3(), {x.ctl, x.fa, x.fb});
      check($sformatf("%s[%0d].w0_freeze", tag, idx), {9'd0, frz0}, 10'd0);
    end else begin
      check($sformatf("%s[%0d]", tag, idx), obs0(), {x.ctl, x.fa, x.fb});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(nop(C_NONE, 2'b00, 2'b00));
    repeat (2) @(posedge clk);
    #1;
    check("reset_w3", obs3(), 10'd0);
    check("reset_w0", obs0(), 10'd0);
    rst_n = 1'b1;

    // Forwarding, $0, load-use, branch priority and jump cases on the no-wait instance.
    tv.push_back(mk(1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // add $3
    tv.push_back(mk(1,  3,  1, 1, 1,  4, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // sub $4,$3
    tv.push_back(mk(1,  3,  3, 1, 1,  6, 1, 0, 0, 0, 0, C_NONE,  2'b10, 2'b00)); // and $6,$3,$3
    tv.push_back(nop(C_NONE, 2'b01, 2'b01));
    tv.push_back(mk(1,  1,  2, 1, 1,  0, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // add $0
    tv.push_back(mk(1,  0,  0, 1, 1,  7, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // sub $7,$0,$0
    tv.push_back(mk(1,  0,  5, 1, 1,  8, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // or $8,$0,$5
    tv.push_back(nop(C_NONE, 2'b00, 2'b00));
    tv.push_back(mk(1,  1,  5, 1, 0,  5, 1, 1, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // lw $5
    tv.push_back(mk(1,  2,  5, 1, 1,  9, 1, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00)); // add $9,$2,$5
    tv.push_back(mk(1,  2,  5, 1, 1,  9, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // retry
    tv.push_back(nop(C_NONE, 2'b00, 2'b01));
    tv.push_back(mk(1,  1,  5, 1, 0,  5, 1, 1, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // lw $5
    tv.push_back(mk(1,  5,  5, 0, 0,  0, 0, 0, 0, 1, 0, C_JMP,   2'b00, 2'b00)); // j (fields 5)
    tv.push_back(nop(C_NONE, 2'b00, 2'b00));
    tv.push_back(mk(1,  1,  1, 1, 1, 11, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // add $11
    tv.push_back(mk(1,  2,  2, 1, 1, 11, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // add $11
    tv.push_back(mk(1, 11, 11, 1, 1, 12, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // sub $12
    tv.push_back(nop(C_NONE, 2'b10, 2'b10));
    tv.push_back(mk(1,  1,  5, 1, 0,  5, 1, 1, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // lw $5
    tv.push_back(mk(1,  5,  7, 1, 0,  7, 1, 1, 0, 0, 1, C_BR,    2'b00, 2'b00)); // lw $7 + branch
    tv.push_back(mk(1,  7,  0, 1, 1, 13, 1, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // add $13,$7
    tv.push_back(mk(1,  1,  6, 1, 0,  6, 1, 1, 0, 0, 0, C_NONE,  2'b00, 2'b00)); // lw $6
    tv.push_back(mk(1,  6,  0, 1, 0,  0, 0, 0, 0, 1, 0, C_STALL, 2'b00, 2'b00)); // jr $6
    tv.push_back(mk(1,  6,  0, 1, 0,  0, 0, 0, 0, 1, 0, C_JMP,   2'b00, 2'b00)); // jr retry
    tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0, C_NONE,  2'b01, 2'b00)); // stray jump
    foreach (tv[i]) apply(tv[i], 1'b0, "fwd", i);

    drive(nop(C_NONE, 2'b00, 2'b00));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // MEM_WAIT=3: freeze length, held forwarding, deferred branch, back-to-back accesses.
    fz.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00)); // add $3
    fz.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, C_NONE, 2'b00, 2'b00)); // sw
    fz.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00)); // sub $4,$3
    for (int k = 0; k < 3; k++)
      fz.push_back(mk(1, 1, 8, 1, 0, 8, 1, 1, 0, 0, 1, C_FRZ, 2'b01, 2'b00));
    fz.push_back(mk(1, 1, 8, 1, 0, 8, 1, 1, 0, 0, 1, C_BR, 2'b01, 2'b00));
    fz.push_back(nop(C_NONE, 2'b00, 2'b00));
    fz.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, C_NONE, 2'b00, 2'b00)); // sw
    fz.push_back(mk(1, 1, 9, 1, 0, 9, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00)); // lw $9
    for (int k = 0; k < 3; k++) fz.push_back(nop(C_FRZ, 2'b00, 2'b00));
    fz.push_back(nop(C_NONE, 2'b00, 2'b00));
    for (int k = 0; k < 3; k++) fz.push_back(nop(C_FRZ, 2'b00, 2'b00));
    fz.push_back(nop(C_NONE, 2'b00, 2'b00));
    fz.push_back(nop(C_NONE, 2'b00, 2'b00));
    fz.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, C_NONE, 2'b00, 2'b00)); // sw
    fz.push_back(nop(C_NONE, 2'b00, 2'b00));
    fz.push_back(nop(C_FRZ, 2'b00, 2'b00));
    fz.push_back(nop(C_FRZ, 2'b00, 2'b00));
    foreach (fz[i]) apply(fz[i], 1'b1, "frz", i);

    // Still in WAIT here; reset must clear everything at once, even with a branch pending.
    ex_branch_taken = 1'b1;
    #1;
    check("wait_before_reset", obs3(), {C_FRZ, 4'b0000});
    rst_n = 1'b0;
    #1;
    check("reset_in_wait_w3", obs3(), 10'd0);
    check("reset_in_wait_w0", obs0(), 10'd0);
    @(posedge clk);
    #1;
    drive(nop(C_NONE, 2'b00, 2'b00));
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) apply(nop(C_NONE, 2'b00, 2'b00), 1'b1, "post_rst", k);
    apply(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, C_NONE, 2'b00, 2'b00), 1'b1, "post_rst_sw", 0);
    apply(nop(C_NONE, 2'b00, 2'b00), 1'b1, "post_rst_sw", 1);
    apply(nop(C_FRZ, 2'b00, 2'b00), 1'b1, "post_rst_sw", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) built around the existing single-cycle datapath blocks. It keeps a shadow copy of the register-usage info for each in-flight instruction and drives operand forwarding selects. It also generates load-use stalls and branch/jump flushes. A wait-state FSM freezes the whole pipeline while a data-memory access completes.

Parameters:
MEM_WAIT, 2, freeze cycles per data-memory access in MEM (0..15; 0 = no freeze).

Ports:
clk  in  1  pipeline clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
id_valid  in  1  ID stage holds a real instruction.
id_rs  in  5  ID source register rs.
id_rt  in  5  ID source register rt.
id_uses_rs  in  1  instruction reads rs.
id_uses_rt  in  1  instruction reads rt.
id_dst  in  5  destination register (after the RegDst mux).
id_regwrite  in  1  instruction writes the register file.
id_memread  in  1  load.
id_memwrite  in  1  store.
id_jump  in  1  jump decoded in ID.
ex_branch_taken  in  1  branch in EX resolved taken.
pc_stall  out  1  hold PC.
ifid_stall  out  1  hold IF/ID register.
idex_bubble  out  1  load zeros (NOP) into ID/EX.
ifid_flush  out  1  clear IF/ID.
idex_flush  out  1  clear ID/EX.
freeze_all  out  1  hold every pipeline register and PC.
fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB write data.
fwd_b  out  2  ALU operand B select (pre-ALUsrc mux), same encoding.

Behaviour:
- Shadow entries EX, MEM, WB each hold: valid, rs, rt, uses_rs, uses_rt, dst, regwrite, memread, memwrite.
- Reset (async, rst_n=0): all entries invalid and zero; FSM in IDLE; count=0; every output 0 (fwd=00).
- Advance on each clk edge when freeze_all=0: WB<=MEM; MEM<=EX.
- EX<=empty if (ex_branch_taken | idex_bubble | !id_valid); otherwise EX<=ID inputs.
- freeze_all=1: all entries hold.
- Register 0: never a hazard source and never forwarded. An entry only counts if valid & regwrite & dst!=0.
- fwd_a: 10 if MEM counts and MEM.dst==EX.rs and !MEM.memread; else 01 if WB counts and WB.dst==EX.rs; else 00. fwd_b is the same with EX.rt.
- EX/MEM forwarding takes priority over MEM/WB. Forwarding is combinational from shadow state and stays valid during freeze.
- Load-use hazard: EX valid & memread & dst!=0 & id_valid & ((id_uses_rs & id_rs==EX.dst) | (id_uses_rt & id_rt==EX.dst)).
- On a load-use hazard: pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle. The stall clears itself because the load moves to MEM.
- Branch taken (EX): ifid_flush=idex_flush=1 for one cycle. This has priority over the load-use stall (stall outputs forced 0).
- Jump (id_valid & id_jump, no branch taken): ifid_flush=1 only. If a load-use hazard is also present, the stall wins and the jump flushes on the retry cycle.
- Memory wait FSM, with mem_acc = MEM valid & (memread | memwrite):
  - IDLE: freeze_all=mem_acc & MEM_WAIT!=0. If frozen: count<=MEM_WAIT-1; next state is DONE if MEM_WAIT==1, else WAIT.
  - WAIT: freeze_all=1; count decrements; when count==1 go to DONE.
  - DONE: freeze_all=0; pipeline advances; mem_acc is ignored; next state IDLE.
  - Total freeze = MEM_WAIT cycles per access. Back-to-back accesses each freeze because the next access is evaluated in IDLE.
- While freeze_all=1: pc_stall, ifid_stall, idex_bubble, ifid_flush and idex_flush are forced 0.
- During freeze, ex_branch_taken and the hazard inputs are ignored; they are re-evaluated on the first unfrozen cycle (the branch stays in EX).
- Reset asserted mid-freeze or mid-stall: immediate return to the reset state, with no partial count retained.

Test Plan:
- add $3 in EX → sub reading $3 enters EX next cycle → fwd_a=10. The cycle after that → fwd_a=01. Same sequence with dst=$0 → fwd_a stays 00.
- lw $5 in EX, ID reads rt=$5 (uses_rt=1) → pc_stall/ifid_stall/idex_bubble=1 for exactly 1 cycle. Next cycle fwd_b=01 from the load in WB.
- ex_branch_taken=1 together with a load-use condition → ifid_flush=idex_flush=1, stall outputs 0. Next EX entry is invalid.
- MEM_WAIT=3, sw enters MEM → freeze_all high for exactly 3 cycles, then 1 unfrozen cycle. Back-to-back lw → another 3-cycle freeze. MEM_WAIT=0 → never frozen.
- ex_branch_taken asserted during freeze → no flush while frozen. Flush pulses on the first unfrozen cycle.
- rst_n pulled low during the WAIT state → all outputs 0 immediately. After release, no freeze until a new access reaches MEM.
